memory_scheduler: RTL and testbench

//  Shares the single core memory port between three requesters: dmem (0), imem (1) and dma (2).
//  It captures one-cycle request pulses into per-requester pending slots and issues one transaction
//  at a time. Arbitration is fixed priority, dmem > imem > dma, with a starvation override.
//  It routes memory_rdata/memory_ready back to the owning requester.
//  It sits between the fetchbuffer/execute data paths (plus an external DMA master) and the cpu memory pins.

---
 rtl/memory_scheduler_pkg.sv | 19 +
 rtl/memory_scheduler_if.sv | 32 +++
 rtl/memory_scheduler_mem_grant.sv | 29 ++
 rtl/memory_scheduler.sv | 106 ++++++++++
 tb/tb_memory_scheduler.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_scheduler_pkg.sv
// Shared types and constants for the three-way memory port scheduler.
package memory_scheduler_pkg;
  localparam int NUM_REQ              = 3;
  localparam int STARVE_LIMIT_DEFAULT = 8;

  localparam logic [1:0] REQ_DMEM = 2'd0;
  localparam logic [1:0] REQ_IMEM = 2'd1;
  localparam logic [1:0] REQ_DMA  = 2'd2;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sched_slot_type;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} sched_state_type;
endpackage

// File: rtl/memory_scheduler_if.sv
// Requester-side and memory-side buses of the scheduler; slave = scheduler, master = environment.
interface memory_scheduler_if;
  import memory_scheduler_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_instr;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0][31:0] req_wdata;
  logic [NUM_REQ-1:0][3:0]  req_wstrb;
  logic [31:0]              req_rdata;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     proto_err;
  logic                     memory_valid;
  logic                     memory_instr;
  logic [31:0]              memory_addr;
  logic [31:0]              memory_wdata;
  logic [3:0]               memory_wstrb;
  logic [31:0]              memory_rdata;
  logic                     memory_ready;

  modport slave (
    input  req_valid, req_instr, req_addr, req_wdata, req_wstrb, memory_rdata, memory_ready,
    output req_rdata, req_ready, proto_err,
           memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb
  );

  modport master (
    output req_valid, req_instr, req_addr, req_wdata, req_wstrb, memory_rdata, memory_ready,
    input  req_rdata, req_ready, proto_err,
           memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb
  );
endinterface

// File: rtl/memory_scheduler_mem_grant.sv
// Combinational grant: starved imem, then starved dma, then fixed priority dmem > imem > dma.
module memory_scheduler_mem_grant
  import memory_scheduler_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CNT_W        = 4
) (
  input  logic [NUM_REQ-1:0] cand,
  input  logic [CNT_W-1:0]   cnt_imem,
  input  logic [CNT_W-1:0]   cnt_dma,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_idx
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic imem_starved, dma_starved;
  assign imem_starved = cand[REQ_IMEM] && (cnt_imem >= LIMIT);
  assign dma_starved  = cand[REQ_DMA]  && (cnt_dma  >= LIMIT);

  always_comb begin
    gnt_idx = REQ_DMEM;
    if      (imem_starved)   gnt_idx = REQ_IMEM;
    else if (dma_starved)    gnt_idx = REQ_DMA;
    else if (cand[REQ_DMEM]) gnt_idx = REQ_DMEM;
    else if (cand[REQ_IMEM]) gnt_idx = REQ_IMEM;
    else if (cand[REQ_DMA])  gnt_idx = REQ_DMA;
    gnt = (|cand) ? (NUM_REQ'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/memory_scheduler.sv
// Shares one memory port among dmem/imem/dma: pending slots with same-cycle bypass,
// one outstanding transaction, back-to-back issue on completion, starvation promotion.
module memory_scheduler
  import memory_scheduler_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CNT_W        = 4
) (
  input logic               clock,
  input logic               reset,
  memory_scheduler_if.slave bus
);
  sched_slot_type     slot   [NUM_REQ];
  sched_slot_type     req_in [NUM_REQ];
  sched_slot_type     issue;
  sched_state_type    state, state_nxt;
  logic [1:0]         owner;
  logic [CNT_W-1:0]   cnt_imem, cnt_dma;
  logic [NUM_REQ-1:0] cand, gnt;
  logic [1:0]         gnt_idx;
  logic               decide;
  logic               proto_err_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign req_in[i] = {bus.req_valid[i], bus.req_instr[i], bus.req_addr[i],
                        bus.req_wdata[i], bus.req_wstrb[i]};
    assign cand[i]   = slot[i].valid | bus.req_valid[i];
  end

  memory_scheduler_mem_grant #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_grant (
    .cand     (cand),
    .cnt_imem (cnt_imem),
    .cnt_dma  (cnt_dma),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  // A pending slot is always older than a same-cycle pulse from that requester.
  assign issue = slot[gnt_idx].valid ? slot[gnt_idx] : req_in[gnt_idx];
  assign bus.proto_err = proto_err_q;

  function automatic logic [CNT_W-1:0] starve_next(logic [CNT_W-1:0] c, logic is_cand,
                                                   logic is_gnt);
    if (is_gnt)                return '0;
    if (is_cand && (c != '1))  return c + CNT_W'(1);
    return c;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    decide           = 1'b0;
    bus.memory_valid = 1'b0;
    bus.memory_instr = 1'b0;
    bus.memory_addr  = '0;
    bus.memory_wdata = '0;
    bus.memory_wstrb = '0;
    bus.req_ready    = '0;
    bus.req_rdata    = '0;
    if (!reset) begin
      unique case (state)
        IDLE: decide = |cand;
        BUSY: if (bus.memory_ready) begin
          bus.req_ready = NUM_REQ'(1) << owner;
          bus.req_rdata = bus.memory_rdata;
          decide        = |cand;
          state_nxt     = IDLE;
        end
        default: ;
      endcase
      if (decide) begin
        state_nxt        = BUSY;
        bus.memory_valid = 1'b1;
        bus.memory_instr = issue.instr;
        bus.memory_addr  = issue.addr;
        bus.memory_wdata = issue.wdata;
        bus.memory_wstrb = issue.wstrb;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner       <= REQ_DMEM;
      cnt_imem    <= '0;
      cnt_dma     <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && slot[i].valid) proto_err_q <= 1'b1;
        if (decide && gnt[i])                          slot[i].valid <= 1'b0;
        else if (bus.req_valid[i] && !slot[i].valid)   slot[i]       <= req_in[i];
      end
      if (decide) begin
        owner    <= gnt_idx;
        cnt_imem <= starve_next(cnt_imem, cand[REQ_IMEM], gnt[REQ_IMEM]);
        cnt_dma  <= starve_next(cnt_dma,  cand[REQ_DMA],  gnt[REQ_DMA]);
      end
    end
  end
endmodule

// File: tb/tb_memory_scheduler.sv
// Directed scenarios plus randomized traffic against a cycle-level reference of the arbitration rules.
module tb_memory_scheduler;
  import memory_scheduler_pkg::*;

  localparam int LIMIT = 8;
  localparam int SAT   = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  memory_scheduler_if bus();
  memory_scheduler #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // stimulus
  logic        rst_v;
  logic [2:0]  rv, ri;
  logic [31:0] ra [3];
  logic [31:0] rd [3];
  logic [3:0]  rs [3];
  logic        mrdy;
  logic [31:0] mrd;
  bit          auto_mem;
  bit          env_out;
  int          env_wait;

  // observations
  logic        o_mvalid, o_perr;
  logic [31:0] o_maddr, o_rdata;
  logic [2:0]  o_ready;

  // reference state
  bit          m_pend [3];
  bit          m_instr[3];
  logic [31:0] m_addr [3];
  logic [31:0] m_wdata[3];
  logic [3:0]  m_wstrb[3];
  int          m_age  [3];
  bit          m_busy;
  int          m_owner;
  bit          m_perr;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0; m_age[i] = 0;
    end
    m_busy = 0; m_owner = 0; m_perr = 0;
  endtask

  task automatic step();
    bit [2:0]    cand;
    bit          complete, decide;
    int          g;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_instr;
    logic [2:0]  e_ready;
    if (auto_mem) begin
      mrdy = 1'b0;
      if (env_out) begin
        if (env_wait == 0) begin
          mrdy = 1'b1; mrd = $urandom;
        end else env_wait--;
      end
    end
    reset = rst_v;
    bus.req_valid = rv;
    bus.req_instr = ri;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr[i]  = ra[i];
      bus.req_wdata[i] = rd[i];
      bus.req_wstrb[i] = rs[i];
    end
    bus.memory_ready = mrdy;
    bus.memory_rdata = mrd;
    #1;
    o_mvalid = bus.memory_valid;
    o_maddr  = bus.memory_addr;
    o_ready  = bus.req_ready;
    o_rdata  = bus.req_rdata;
    o_perr   = bus.proto_err;
    if (rst_v) begin
      chk("rst_mvalid", 32'(o_mvalid), 32'd0);
      chk("rst_ready",  32'(o_ready),  32'd0);
      chk("rst_rdata",  o_rdata,       32'd0);
      chk("rst_maddr",  o_maddr,       32'd0);
      model_reset();
      env_out = 0;
    end else begin
      for (int i = 0; i < 3; i++) cand[i] = m_pend[i] || rv[i];
      complete = m_busy && mrdy;
      decide   = (cand != 0) && (!m_busy || mrdy);
      g = -1;
      if (decide) begin
        if (cand[1] && m_age[1] >= LIMIT)      g = 1;
        else if (cand[2] && m_age[2] >= LIMIT) g = 2;
        else if (cand[0])                      g = 0;
        else if (cand[1])                      g = 1;
        else                                   g = 2;
      end
      e_ready = complete ? 3'(1 << m_owner) : 3'b000;
      chk("mvalid", 32'(o_mvalid), 32'(decide));
      chk("ready",  32'(o_ready),  32'(e_ready));
      chk("perr",   32'(o_perr),   32'(m_perr));
      if (complete) chk("rdata", o_rdata, mrd);
      if (decide) begin
        if (m_pend[g]) begin
          e_addr = m_addr[g]; e_wdata = m_wdata[g]; e_wstrb = m_wstrb[g]; e_instr = m_instr[g];
        end else begin
          e_addr = ra[g]; e_wdata = rd[g]; e_wstrb = rs[g]; e_instr = ri[g];
        end
        chk("maddr",  o_maddr,                  e_addr);
        chk("mwdata", bus.memory_wdata,         e_wdata);
        chk("mwstrb", 32'(bus.memory_wstrb),    32'(e_wstrb));
        chk("minstr", 32'(bus.memory_instr),    32'(e_instr));
      end
      // advance the reference
      for (int i = 0; i < 3; i++) begin
        if (rv[i] && m_pend[i]) m_perr = 1;
        if (decide && g == i) m_pend[i] = 0;
        else if (rv[i] && !m_pend[i]) begin
          m_pend[i] = 1; m_addr[i] = ra[i]; m_wdata[i] = rd[i];
          m_wstrb[i] = rs[i]; m_instr[i] = ri[i];
        end
      end
      if (decide) begin
        for (int i = 1; i < 3; i++) begin
          if (g == i)       m_age[i] = 0;
          else if (cand[i]) m_age[i] = (m_age[i] < SAT) ? m_age[i] + 1 : SAT;
        end
        m_busy = 1; m_owner = g;
      end else if (complete) m_busy = 0;
      if (auto_mem) begin
        if (mrdy) env_out = 0;
        if (decide) begin
          env_out = 1; env_wait = $urandom_range(0, 3);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic set_req(logic [2:0] v, logic [31:0] a0, logic [31:0] a1, logic [31:0] a2);
    rv = v; ri = 3'b000;
    ra[0] = a0; ra[1] = a1; ra[2] = a2;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 32'h1111_0000 + 32'(i); rs[i] = 4'h0;
    end
  endtask

  initial begin
    rst_v = 1; mrdy = 0; mrd = 0; auto_mem = 0; env_out = 0; env_wait = 0;
    set_req(3'b000, 0, 0, 0);
    model_reset();
    @(negedge clock);
    step(); step();
    rst_v = 0;
    step();
    chk("post_rst_perr",  32'(o_perr),    32'd0);
    chk("post_rst_state", 32'(dut.state), 32'(IDLE));

    // single dmem read, completion three cycles later
    set_req(3'b001, 32'h100, 0, 0); step();
    chk("t1_mvalid", 32'(o_mvalid), 32'd1);
    chk("t1_maddr",  o_maddr, 32'h100);
    set_req(3'b000, 0, 0, 0); step(); step();
    mrdy = 1; mrd = 32'hDEAD_BEEF; step();
    chk("t1_ready", 32'(o_ready), 32'b001);
    chk("t1_rdata", o_rdata, 32'hDEAD_BEEF);
    mrdy = 0; step();

    // three simultaneous requests issue in priority order, back-to-back
    set_req(3'b111, 32'h200, 32'h204, 32'h208); step();
    chk("t2_first", o_maddr, 32'h200);
    set_req(3'b000, 0, 0, 0); step();
    mrdy = 1; mrd = 32'h0A; step();
    chk("t2_rdy0", 32'(o_ready), 32'b001);
    chk("t2_second", o_maddr, 32'h204);
    step();
    chk("t2_rdy1", 32'(o_ready), 32'b010);
    chk("t2_third", o_maddr, 32'h208);
    step();
    chk("t2_rdy2", 32'(o_ready), 32'b100);
    chk("t2_idle", 32'(o_mvalid), 32'd0);
    mrdy = 0;

    // starvation: dma promoted at its 9th grant decision
    set_req(3'b101, 32'h600, 0, 32'h700); step();
    for (int k = 2; k <= 9; k++) begin
      set_req(3'b001, 32'h600, 0, 32'h700); mrdy = 1; step();
      chk((k == 9) ? "t3_dma_promoted" : "t3_dmem_wins", o_maddr, (k == 9) ? 32'h700 : 32'h600);
    end
    chk("t3_cnt_cleared", 32'(dut.cnt_dma), 32'd0);
    set_req(3'b000, 0, 0, 0); step(); step();
    chk("t3_drained", 32'(o_ready), 32'b001);
    mrdy = 0;

    // owner re-request in its completion cycle beats a pending dma
    set_req(3'b110, 0, 32'h800, 32'h900); step();
    set_req(3'b000, 0, 0, 0); step();
    set_req(3'b010, 0, 32'h804, 0); mrdy = 1; step();
    chk("t4_ready", 32'(o_ready), 32'b010);
    chk("t4_imem_wins", o_maddr, 32'h804);
    set_req(3'b000, 0, 0, 0); step();
    chk("t4_dma_next", o_maddr, 32'h900);
    step();
    chk("t4_perr", 32'(o_perr), 32'd0);
    mrdy = 0;

    // double dma pulse while pending
    set_req(3'b001, 32'hA00, 0, 0); step();
    set_req(3'b100, 0, 0, 32'h300); step();
    set_req(3'b100, 0, 0, 32'h304); step();
    set_req(3'b000, 0, 0, 0); step();
    chk("t5_perr", 32'(o_perr), 32'd1);
    mrdy = 1; step();
    chk("t5_first_addr", o_maddr, 32'h300);
    step();
    chk("t5_no_second", 32'(o_mvalid), 32'd0);
    mrdy = 0; step();
    chk("t5_still_quiet", 32'(o_mvalid), 32'd0);

    // reset in BUSY, then a stale completion
    rst_v = 1; step(); rst_v = 0; step();
    chk("t6_perr_clr", 32'(o_perr), 32'd0);
    set_req(3'b001, 32'h400, 0, 0); step();
    set_req(3'b000, 0, 0, 0); step();
    rst_v = 1; step(); rst_v = 0;
    mrdy = 1; mrd = 32'h5555_AAAA; step();
    chk("t6_no_ready", 32'(o_ready), 32'd0);
    chk("t6_state", 32'(dut.state), 32'(IDLE));
    mrdy = 0;
    set_req(3'b010, 0, 32'h500, 0); step();
    chk("t6_reissue", o_maddr, 32'h500);
    set_req(3'b000, 0, 0, 0); mrdy = 1; mrd = 32'h77; step();
    chk("t6_ready", 32'(o_ready), 32'b010);
    mrdy = 0; step();

    // randomized legal traffic with a random-latency memory
    auto_mem = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        rv[i] = !m_pend[i] && ($urandom_range(0, 99) < ((i == 0) ? 60 : 25));
        ri[i] = 1'($urandom_range(0, 1));
        ra[i] = $urandom; rd[i] = $urandom; rs[i] = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
